// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bus: groups every non-clock/reset signal of pipe_ctrl.
//   master : core-side driver of fetch/stall/redirect requests, observer of stage state
//   slave  : the sequencer itself (pipe_ctrl)
// Signals:
//   fetch_en, stall_req[STAGES], redirect_valid/stage/pc  -> sequencer
//   redirect_ack, stage_valid, stage_pc (flat, stage i at [i*PC_W +: PC_W]),
//   fetch_pc, retire_valid, retire_pc, retire_cnt         <- sequencer
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned PC_W   = 24,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned SW = $clog2(STAGES);

  logic                   fetch_en;
  logic [STAGES-1:0]      stall_req;
  logic                   redirect_valid;
  logic [SW-1:0]          redirect_stage;
  logic [PC_W-1:0]        redirect_pc;
  logic                   redirect_ack;
  logic [STAGES-1:0]      stage_valid;
  logic [STAGES*PC_W-1:0] stage_pc;
  logic [PC_W-1:0]        fetch_pc;
  logic                   retire_valid;
  logic [PC_W-1:0]        retire_pc;
  logic [CNT_W-1:0]       retire_cnt;

  modport master (
    output fetch_en, stall_req, redirect_valid, redirect_stage, redirect_pc,
    input  redirect_ack, stage_valid, stage_pc, fetch_pc, retire_valid, retire_pc, retire_cnt
  );

  modport slave (
    input  fetch_en, stall_req, redirect_valid, redirect_stage, redirect_pc,
    output redirect_ack, stage_valid, stage_pc, fetch_pc, retire_valid, retire_pc, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Parametrised in-order pipeline sequencer. Owns the fetch PC and a valid/PC tag per stage,
// resolving per-stage stalls (hold below the highest stalled stage, bubble just above it),
// branch redirects with wrong-path squash, and retire reporting with a saturating counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_ctrl_if.slave (requests in, stage state / retire info out)
module pipe_ctrl #(
  parameter int unsigned     STAGES   = 5,
  parameter int unsigned     PC_W     = 24,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned SW   = $clog2(STAGES);
  localparam int unsigned Last = STAGES - 1;

  logic [STAGES-1:0]      valid_q, valid_d;
  logic [STAGES*PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STAGES-1:0]      hold;
  logic                   redir_ok;
  logic                   retire;

  // hold[i] = some stage at or above i is stalled, i.e. i <= k.
  // A redirect is blocked when any stall sits at or above the redirecting stage.
  always_comb begin : p_stall
    logic acc;
    logic blocked;
    logic legal;
    acc     = 1'b0;
    blocked = 1'b0;
    hold    = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | bus.stall_req[i];
      hold[i] = acc;
      if (bus.stall_req[i] && (i >= int'(bus.redirect_stage))) blocked = 1'b1;
    end
    legal    = (bus.redirect_stage != '0) && (int'(bus.redirect_stage) < int'(STAGES));
    redir_ok = bus.redirect_valid && legal && !blocked;
  end

  always_comb begin : p_next
    valid_d    = valid_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;

    if (redir_ok) begin
      valid_d[0]        = 1'b1;
      pc_d[0 +: PC_W]   = bus.redirect_pc;
      fetch_pc_d        = bus.redirect_pc + PC_W'(PC_STEP);
    end else if (!hold[0]) begin
      valid_d[0]        = bus.fetch_en;
      pc_d[0 +: PC_W]   = fetch_pc_q;
      if (bus.fetch_en) fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
    end

    for (int i = 1; i < STAGES; i++) begin
      if (redir_ok && (i <= int'(bus.redirect_stage))) begin
        // Wrong-path squash overrides any stall on these stages.
        valid_d[i] = 1'b0;
      end else if (!hold[i]) begin
        if (hold[i-1]) begin
          valid_d[i] = 1'b0;  // bubble; PC left as-is
        end else begin
          valid_d[i]               = valid_q[i-1];
          pc_d[i*PC_W +: PC_W]     = pc_q[(i-1)*PC_W +: PC_W];
        end
      end
    end

    retire = valid_q[Last] && !bus.stall_req[Last];
    cnt_d  = cnt_q;
    if (retire && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      pc_q       <= '0;
      fetch_pc_q <= RESET_PC;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.redirect_ack = redir_ok;
  assign bus.stage_valid  = valid_q;
  assign bus.stage_pc     = pc_q;
  assign bus.fetch_pc     = fetch_pc_q;
  assign bus.retire_valid = retire;
  assign bus.retire_pc    = pc_q[Last*PC_W +: PC_W];
  assign bus.retire_cnt   = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 24-bit/32-bit-counter instance for fill, stall, redirect,
// illegal redirect and async reset, and an 8-bit/4-bit-counter instance for PC wrap and
// retire counter saturation.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(5), .PC_W(24), .CNT_W(32)) a_if ();
  pipe_ctrl_if #(.STAGES(5), .PC_W(8),  .CNT_W(4))  b_if ();

  pipe_ctrl #(.STAGES(5), .PC_W(24), .PC_STEP(4), .RESET_PC(24'h0), .CNT_W(32)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if)
  );

  pipe_ctrl #(.STAGES(5), .PC_W(8), .PC_STEP(4), .RESET_PC(8'h0), .CNT_W(4)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pa(input int i);
    return a_if.stage_pc[i*24 +: 24];
  endfunction

  initial begin
    rst_n             = 1'b0;
    a_if.fetch_en       = 1'b0;
    a_if.stall_req      = '0;
    a_if.redirect_valid = 1'b0;
    a_if.redirect_stage = '0;
    a_if.redirect_pc    = '0;
    b_if.fetch_en       = 1'b0;
    b_if.stall_req      = '0;
    b_if.redirect_valid = 1'b0;
    b_if.redirect_stage = '0;
    b_if.redirect_pc    = '0;

    #2;
    chk("rst_valid", a_if.stage_valid, 5'b00000);
    chk("rst_fetch", a_if.fetch_pc, 24'h0);
    chk("rst_cnt",   a_if.retire_cnt, 32'd0);
    chk("rst_pc",    a_if.stage_pc, 120'h0);

    #10;  // t=12, next posedge at 15
    rst_n         = 1'b1;
    a_if.fetch_en = 1'b1;

    // Fill
    tick;
    chk("fill1_valid", a_if.stage_valid, 5'b00001);
    chk("fill1_fetch", a_if.fetch_pc, 24'd4);
    tick;
    chk("fill2_valid", a_if.stage_valid, 5'b00011);
    chk("fill2_s1",    pa(1), 24'd0);
    tick;
    chk("fill3_valid", a_if.stage_valid, 5'b00111);
    tick;
    chk("fill4_valid", a_if.stage_valid, 5'b01111);
    chk("fill4_ret",   a_if.retire_valid, 1'b0);
    tick;
    chk("fill5_valid", a_if.stage_valid, 5'b11111);
    chk("fill5_ret",   a_if.retire_valid, 1'b1);
    chk("fill5_rpc",   a_if.retire_pc, 24'd0);
    chk("fill5_s0",    pa(0), 24'd16);
    chk("fill5_fetch", a_if.fetch_pc, 24'd20);
    chk("fill5_cnt",   a_if.retire_cnt, 32'd0);
    tick;
    chk("t6_cnt",   a_if.retire_cnt, 32'd1);
    chk("t6_rpc",   a_if.retire_pc, 24'd4);

    // Stall at stage 2 for two cycles
    a_if.stall_req = 5'b00100;
    #1;
    chk("st_ret_comb", a_if.retire_valid, 1'b1);
    tick;
    chk("st1_valid", a_if.stage_valid, 5'b10111);
    chk("st1_s0",    pa(0), 24'd20);
    chk("st1_s2",    pa(2), 24'd12);
    chk("st1_s4",    pa(4), 24'd8);
    chk("st1_fetch", a_if.fetch_pc, 24'd24);
    chk("st1_cnt",   a_if.retire_cnt, 32'd2);
    tick;
    chk("st2_valid", a_if.stage_valid, 5'b00111);
    chk("st2_fetch", a_if.fetch_pc, 24'd24);
    chk("st2_cnt",   a_if.retire_cnt, 32'd3);
    a_if.stall_req = 5'b00000;
    #1;
    chk("gap1_ret", a_if.retire_valid, 1'b0);
    tick;
    chk("rs1_valid", a_if.stage_valid, 5'b01111);
    chk("rs1_s0",    pa(0), 24'd24);
    chk("rs1_s3",    pa(3), 24'd12);
    chk("gap2_ret",  a_if.retire_valid, 1'b0);
    chk("rs1_fetch", a_if.fetch_pc, 24'd28);
    tick;
    chk("rs2_valid", a_if.stage_valid, 5'b11111);
    chk("rs2_rpc",   a_if.retire_pc, 24'd12);
    chk("rs2_cnt",   a_if.retire_cnt, 32'd3);

    // Redirect from stage 2 to 0x100
    a_if.redirect_valid = 1'b1;
    a_if.redirect_stage = 3'd2;
    a_if.redirect_pc    = 24'h100;
    #1;
    chk("rd_ack", a_if.redirect_ack, 1'b1);
    tick;
    a_if.redirect_valid = 1'b0;
    chk("rd_valid", a_if.stage_valid, 5'b11001);
    chk("rd_s0",    pa(0), 24'h100);
    chk("rd_s3",    pa(3), 24'd20);
    chk("rd_s4",    pa(4), 24'd16);
    chk("rd_fetch", a_if.fetch_pc, 24'h104);
    chk("rd_cnt",   a_if.retire_cnt, 32'd4);

    // Redirect held while stage 3 stalls
    a_if.stall_req      = 5'b01000;
    a_if.redirect_valid = 1'b1;
    a_if.redirect_stage = 3'd2;
    a_if.redirect_pc    = 24'h200;
    #1;
    chk("bl_ack", a_if.redirect_ack, 1'b0);
    chk("bl_ret", a_if.retire_valid, 1'b1);
    chk("bl_rpc", a_if.retire_pc, 24'd16);
    tick;
    chk("bl_valid", a_if.stage_valid, 5'b01001);
    chk("bl_s0",    pa(0), 24'h100);
    chk("bl_fetch", a_if.fetch_pc, 24'h104);
    chk("bl_cnt",   a_if.retire_cnt, 32'd5);
    a_if.stall_req = 5'b00000;
    #1;
    chk("ub_ack", a_if.redirect_ack, 1'b1);
    tick;
    a_if.redirect_valid = 1'b0;
    chk("ub_valid", a_if.stage_valid, 5'b10001);
    chk("ub_s0",    pa(0), 24'h200);
    chk("ub_s4",    pa(4), 24'd20);
    chk("ub_fetch", a_if.fetch_pc, 24'h204);
    chk("ub_cnt",   a_if.retire_cnt, 32'd5);

    // Illegal redirect stages are ignored
    a_if.redirect_valid = 1'b1;
    a_if.redirect_stage = 3'd0;
    a_if.redirect_pc    = 24'h300;
    #1;
    chk("il0_ack", a_if.redirect_ack, 1'b0);
    a_if.redirect_stage = 3'd5;
    #1;
    chk("il5_ack", a_if.redirect_ack, 1'b0);
    tick;
    a_if.redirect_valid = 1'b0;
    chk("il_fetch", a_if.fetch_pc, 24'h208);
    chk("il_s0",    pa(0), 24'h204);
    chk("il_valid", a_if.stage_valid, 5'b00011);
    chk("il_cnt",   a_if.retire_cnt, 32'd6);

    // Async reset mid-stall and mid-redirect
    a_if.stall_req      = 5'b00010;
    a_if.redirect_valid = 1'b1;
    a_if.redirect_stage = 3'd3;
    a_if.redirect_pc    = 24'h400;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", a_if.stage_valid, 5'b00000);
    chk("ar_pc",    a_if.stage_pc, 120'h0);
    chk("ar_fetch", a_if.fetch_pc, 24'h0);
    chk("ar_cnt",   a_if.retire_cnt, 32'd0);
    chk("ar_ret",   a_if.retire_valid, 1'b0);
    a_if.stall_req      = '0;
    a_if.redirect_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick;
    chk("ar_rel_valid", a_if.stage_valid, 5'b00001);
    chk("ar_rel_fetch", a_if.fetch_pc, 24'd4);

    // Narrow instance: PC wrap and counter saturation
    b_if.redirect_valid = 1'b1;
    b_if.redirect_stage = 3'd1;
    b_if.redirect_pc    = 8'hF8;
    #1;
    chk("b_ack", b_if.redirect_ack, 1'b1);
    tick;
    b_if.redirect_valid = 1'b0;
    b_if.fetch_en       = 1'b1;
    chk("b_fetch_fc", b_if.fetch_pc, 8'hFC);
    tick;
    chk("b_wrap",  b_if.fetch_pc, 8'h00);
    chk("b_s0_fc", b_if.stage_pc[7:0], 8'hFC);
    tick;
    chk("b_s0_00", b_if.stage_pc[7:0], 8'h00);
    chk("b_fetch_04", b_if.fetch_pc, 8'h04);
    for (int n = 0; n < 16; n++) tick;
    chk("b_cnt14", b_if.retire_cnt, 4'd14);
    tick;
    chk("b_cnt15", b_if.retire_cnt, 4'd15);
    for (int n = 0; n < 13; n++) tick;
    chk("b_cnt_sat", b_if.retire_cnt, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencer: owns the fetch PC and a per-stage valid/PC tag for an N-stage in-order pipeline.
- Generalises the fixed 5-stage, global-enable shift to the following:
  - per-stage stall with bubble insertion
  - branch redirect with wrong-path squash
  - retire reporting and a retire counter
- Sits at the top of the core; datapath stages read stage_valid/stage_pc to qualify their own registers.

Parameters:
- STAGES, 5, number of pipeline stages (stage 0 = fetch, stage STAGES-1 = writeback); legal 2..16.
- PC_W, 24, PC width in bits.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 0, fetch PC after reset.
- CNT_W, 32, retire counter width.
- SW (localparam), $clog2(STAGES), stage-index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = stage 0 loads a valid fetch; 0 = stage 0 loads a bubble
- stall_req  in  STAGES  bit i = stage i cannot advance this cycle
- redirect_valid  in  1  branch resolved taken / redirect request
- redirect_stage  in  SW  index of the stage holding the redirecting instruction, 1..STAGES-1
- redirect_pc  in  PC_W  target PC
- redirect_ack  out  1  redirect applied this cycle (combinational)
- stage_valid  out  STAGES  registered valid per stage
- stage_pc  out  STAGES*PC_W  registered PC per stage; stage i at [i*PC_W +: PC_W]
- fetch_pc  out  PC_W  PC that stage 0 loads at the next advance
- retire_valid  out  1  last stage valid and leaving this cycle (combinational)
- retire_pc  out  PC_W  PC of the retiring instruction (= stage_pc of the last stage)
- retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, stage_valid=0, stage_pc=0, retire_cnt=0.
  - Takes effect immediately, including mid-stall and mid-redirect.
- Stall resolution:
  - k = highest i with stall_req[i]=1, or -1 if none.
  - Stages 0..k hold both valid and PC.
  - Stage k+1 (if < STAGES) loads a bubble: valid=0, PC unchanged.
  - Stages above k+1 advance (stage i <= stage i-1).
  - stall_req on an invalid stage still stalls.
- Normal advance (k=-1, no redirect):
  - stage 0 <= {fetch_en, fetch_pc}.
  - If fetch_en=1, fetch_pc <= fetch_pc+PC_STEP; otherwise fetch_pc holds.
  - Arithmetic is modulo 2^PC_W (wraps silently).
- Fetch under stall: if k >= 0, stage 0 is held and fetch_pc does not change.
- Redirect acceptance:
  - redirect_ack = redirect_valid && (k < redirect_stage).
  - If not accepted, the redirect has no effect; the source must hold its request until acked.
- Redirect applied (redirect_ack=1):
  - Stages 1..redirect_stage <= invalid (wrong path squashed). These are squashed even if they also had stall_req set.
  - Stage 0 <= {1, redirect_pc}, regardless of fetch_en.
  - fetch_pc <= redirect_pc+PC_STEP.
  - Stages above redirect_stage advance normally; the branch itself moves on to redirect_stage+1.
- redirect_stage = 0 or >= STAGES: treated as redirect_ack=0 (illegal, ignored).
- Retire:
  - retire_valid = stage_valid[STAGES-1] && (k < STAGES-1).
  - retire_pc = stage_pc of stage STAGES-1.
  - retire_cnt increments on retire_valid and saturates at 2^CNT_W-1.
- Latency: a fetched instruction with no stalls retires STAGES-1 cycles after entering stage 0.

Test Plan:
- Reset release, fetch_en=1, no stalls, STAGES=5: fetch PCs 0,4,8,... enter stage 0. stage_valid fills 00001→11111 over 5 cycles. The first retire is PC 0 on cycle 5; retire_cnt=1.
- Steady state, stall_req=00100 for 2 cycles:
  - stages 0-2 hold and fetch_pc is frozen.
  - stage 3 shows valid=0 for 2 cycles.
  - stages 3-4 drain.
  - The retire sequence has exactly two gaps; no PC is lost or duplicated.
- Redirect at stage 2 to PC 0x100 while stages 0-4 are valid: redirect_ack=1. Next cycle:
  - stage0={1,0x100}, stages 1-2 invalid.
  - stage 3 holds the branch PC.
  - fetch_pc=0x104.
- redirect_valid held with stall_req=01000 and redirect_stage=2: redirect_ack=0 and state shows stall-only behaviour. When the stall drops, ack=1 and the redirect applies.
- rst_n pulsed low mid-stall and mid-redirect: all outputs return to reset values asynchronously. With PC_W=8 and fetch_pc=0xFC, the next fetch wraps to 0x00. With CNT_W=4 and 20 retires, retire_cnt stays at 15.
